// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch pulse driver.
package sr_drv_pkg;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned PULSE_W_DEF = 4;
  localparam int unsigned GUARD_W_DEF = 2;

  typedef enum logic [2:0] {
    INIT_R,
    IDLE,
    SET_P,
    CLR_P,
    GUARD,
    DONE
  } state_e;

endpackage

// File: rtl/sr_pulse_timer.sv
// Down-counter for pulse and guard phases; expired is high while the count is zero.
module sr_pulse_timer
  import sr_drv_pkg::*;
(
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // No reset of its own: the parent keeps load asserted throughout its reset.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt     <= load_val;
      expired <= (load_val == '0);
    end else begin
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      expired <= (cnt <= CNT_W'(1));
    end
  end

endmodule

// File: rtl/sr_pulse_driver.sv
// Drives S/R pulses into an external SR latch with a guard gap after each pulse.
// Optional readback check of q_fb against q_exp when SR_READBACK_EN is defined.
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_W = PULSE_W_DEF,
  parameter int unsigned GUARD_W = GUARD_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic S,
  output logic R,
  output logic ready,
  output logic done,
  output logic conflict,
  output logic q_exp,
  output logic err
);

  // The init pulse also spans the reset cycle, hence one extra count.
  localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_W - 1);

  state_e           state;
  state_e           state_nxt;
  logic             init_q;
  logic             expired;
  logic             load_c;
  logic [CNT_W-1:0] load_val_c;
  logic             accept_c;

  assign accept_c = (state == IDLE) || (state == DONE);

  always_comb begin
    state_nxt  = state;
    load_c     = 1'b0;
    load_val_c = '0;
    case (state)
      INIT_R, SET_P, CLR_P: begin
        if (expired) begin
          state_nxt  = GUARD;
          load_c     = 1'b1;
          load_val_c = GUARD_LOAD;
        end
      end
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (set_req && !clr_req) begin
          state_nxt  = SET_P;
          load_c     = 1'b1;
          load_val_c = PULSE_LOAD;
        end else if (clr_req && !set_req) begin
          state_nxt  = CLR_P;
          load_c     = 1'b1;
          load_val_c = PULSE_LOAD;
        end
      end
      GUARD: begin
        if (expired) begin
          state_nxt = init_q ? IDLE : DONE;
        end
      end
      default: state_nxt = INIT_R;
    endcase
    if (reset) begin
      load_c     = 1'b1;
      load_val_c = INIT_LOAD;
    end
  end

  sr_pulse_timer u_timer (
    .clk      (clk),
    .load     (load_c),
    .load_val (load_val_c),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT_R;
      init_q   <= 1'b1;
      S        <= 1'b0;
      R        <= 1'b0;
      ready    <= 1'b0;
      done     <= 1'b0;
      conflict <= 1'b0;
      q_exp    <= 1'b0;
    end else begin
      state    <= state_nxt;
      S        <= (state_nxt == SET_P);
      R        <= (state_nxt == CLR_P) || (state_nxt == INIT_R);
      ready    <= (state_nxt == IDLE) || (state_nxt == DONE);
      done     <= (state_nxt == DONE);
      conflict <= accept_c && set_req && clr_req;
      // Expected latch value is committed at the end of the pulse.
      if ((state_nxt == GUARD) && (state != GUARD)) begin
        q_exp <= (state == SET_P);
      end
      if ((state == GUARD) && expired) begin
        init_q <= 1'b0;
      end
    end
  end

`ifdef SR_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((state == GUARD) && expired && (q_fb != q_exp)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Randomized bench for sr_pulse_driver against a transaction-level model and an SR latch model.
module tb_sr_pulse_driver;

  localparam int P = 4;
  localparam int G = 2;

  localparam int M_IDLE = 0;
  localparam int M_INIT = 1;
  localparam int M_SET  = 2;
  localparam int M_CLR  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic bad_fb = 1'b0;
  logic latch_q = 1'b0;
  logic q_fb;
  logic s_out, r_out, ready, done, conflict, q_exp, err;

  int checks = 0;
  int failures = 0;

  // Model state: mode of the current activity and cycles elapsed since it started.
  int   m_mode = M_INIT;
  int   m_k = 0;
  logic m_q = 1'b0;
  logic m_err = 1'b0;
  logic m_conf = 1'b0;

  always #5 clk = ~clk;

  sr_pulse_driver #(.PULSE_W(P), .GUARD_W(G)) dut (
    .clk      (clk),
    .reset    (reset),
    .set_req  (set_req),
    .clr_req  (clr_req),
    .q_fb     (q_fb),
    .S        (s_out),
    .R        (r_out),
    .ready    (ready),
    .done     (done),
    .conflict (conflict),
    .q_exp    (q_exp),
    .err      (err)
  );

  // External SR latch with a short propagation delay; bad_fb forces a wrong readback.
  always @(s_out, r_out) begin
    #2;
    if (s_out && !r_out) latch_q = 1'b1;
    else if (r_out && !s_out) latch_q = 1'b0;
  end
  assign q_fb = bad_fb ? 1'b0 : latch_q;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%b expected=%b", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_ready();
    return (m_mode == M_IDLE) || (m_mode != M_INIT && m_k == P + G + 1);
  endfunction

  function automatic logic in_pulse();
    return (m_mode != M_IDLE) && (m_k >= 1) && (m_k <= P);
  endfunction

  task automatic model_step(input logic rst, input logic sr, input logic cr, input logic fb);
    if (rst) begin
      m_mode = M_INIT;
      m_k    = 0;
      m_q    = 1'b0;
      m_err  = 1'b0;
      m_conf = 1'b0;
    end else if (exp_ready()) begin
      m_conf = sr && cr;
      if (sr && !cr) begin
        m_mode = M_SET;
        m_k    = 1;
      end else if (cr && !sr) begin
        m_mode = M_CLR;
        m_k    = 1;
      end else begin
        m_mode = M_IDLE;
      end
    end else begin
      m_conf = 1'b0;
`ifdef SR_READBACK_EN
      if (m_k == P + G && fb != m_q) m_err = 1'b1;
`else
      if (fb === 1'bx) m_err = 1'b0;
`endif
      m_k++;
      if (m_k == P + 1) m_q = (m_mode == M_SET);
      if (m_mode == M_INIT && m_k == P + G + 1) m_mode = M_IDLE;
    end
  endtask

  task automatic compare();
    logic exp_done;
    exp_done = (m_mode == M_SET || m_mode == M_CLR) && (m_k == P + G + 1);
    check("S", s_out, (m_mode == M_SET) && in_pulse());
    check("R", r_out, (m_mode == M_CLR || m_mode == M_INIT) && in_pulse());
    check("s_r_excl", s_out & r_out, 1'b0);
    check("ready", ready, exp_ready());
    check("done", done, exp_done);
    check("conflict", conflict, m_conf);
    check("q_exp", q_exp, m_q);
    check("err", err, m_err);
    if (exp_done && !bad_fb) check("latch_q", q_fb, m_q);
  endtask

  task automatic cycle(input logic rst, input logic sr, input logic cr, input logic bad);
    logic fb_s;
    reset   = rst;
    set_req = sr;
    clr_req = cr;
    bad_fb  = bad;
    @(posedge clk);
    fb_s = q_fb;
    model_step(rst, sr, cr, fb_s);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and init R pulse
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    // Set, then conflict, then clear
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    // Clear request during an active set pulse is ignored
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
    // Repeated set while q_exp is already 1, back to back from DONE
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    // Bad readback during a set, then good transactions
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    // Reset in the second cycle of an S pulse
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end
    idle(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_pulse_driver.md
SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 The block SHALL have parameter PULSE_W, default 4, giving the S/R pulse width in clk cycles (legal range 1..255).
REQ-002 The block SHALL have parameter GUARD_W, default 2, giving the settle gap after each pulse in clk cycles (legal range 1..255).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high: clk input 1 bit, rising-edge clock.
REQ-004 reset input 1: synchronous, active-high reset.
REQ-005 set_req input 1: request to drive the latch to Q=1, sampled only while ready=1.
REQ-006 clr_req input 1: request to drive the latch to Q=0, sampled only while ready=1.
REQ-007 q_fb input 1: Q fed back from the external SR latch.
REQ-008 S output 1: latch set drive, registered.
REQ-009 R output 1: latch reset drive, registered.
REQ-010 ready output 1: block is idle and accepts a request.
REQ-011 done output 1: one-cycle pulse when a transaction completes.
REQ-012 conflict output 1: one-cycle pulse when set_req and clr_req are sampled together.
REQ-013 q_exp output 1: expected latch state.
REQ-014 err output 1: sticky readback mismatch flag.

Function
REQ-015 The FSM SHALL have the states INIT_R, IDLE, SET_P, CLR_P, GUARD and DONE.
REQ-016 IDLE SHALL assert ready=1 and hold S=R=0.
- In IDLE with set_req=1 and clr_req=0: next state SET_P.
- In IDLE with clr_req=1 and set_req=0: next state CLR_P.
REQ-017 S and R SHALL never both be 1 in any cycle.
- In IDLE with set_req=1 and clr_req=1: no pulse, conflict=1 next cycle, stay in IDLE.
REQ-018 SET_P SHALL drive S=1 and CLR_P SHALL drive R=1, each for exactly PULSE_W cycles.
- The pulse starts in the cycle after acceptance.
REQ-019 After the pulse, q_exp SHALL take the target value and the FSM SHALL enter GUARD.
- GUARD lasts GUARD_W cycles with S=R=0.
REQ-020 DONE SHALL last one cycle with done=1 and ready=1.
- DONE accepts a new request exactly as IDLE does, so back-to-back transactions are possible.
REQ-021 A request whose target already equals q_exp SHALL still issue a full pulse, because the latch may have been disturbed externally.
REQ-022 Requests SHALL be ignored while ready=0, with no queuing and no conflict pulse.
REQ-023 Transaction latency SHALL be PULSE_W+GUARD_W+1 cycles from the acceptance edge to the done cycle.
REQ-024 The pulse/guard counter SHALL be 8 bits and count down to zero without wrap.

Reset
REQ-025 While reset=1, the block SHALL hold S=0, R=0, ready=0, done=0, conflict=0, q_exp=0 and err=0.
REQ-026 After reset deasserts, the block SHALL enter INIT_R: an automatic R pulse of PULSE_W cycles followed by GUARD, ending in IDLE with no done pulse.
- ready first rises PULSE_W+GUARD_W+1 cycles after reset deasserts.
REQ-027 Reset asserted mid-pulse SHALL drop S/R in the next cycle and restart from REQ-025/REQ-026.

Configuration
REQ-028 Macro SR_READBACK_EN:
- Defined: in the last GUARD cycle, q_fb is compared with q_exp; a mismatch sets err=1 until reset.
- Undefined: err is tied to 0, q_fb is ignored, and the port list is unchanged.

Structure
REQ-029 Package sr_drv_pkg SHALL hold the FSM state enum type, the counter width constant (8) and the default PULSE_W/GUARD_W values.
REQ-030 The counter SHALL be one sub-module, sr_pulse_timer:
- Inputs: load and load value.
- Output: expired.
- All other logic stays in the top module.

Verification (PULSE_W=4, GUARD_W=2, latch model with 2 ns NOR delays, 10 ns clk)
REQ-031 Release reset -> R=1 for cycles 1-4, S=0 throughout, ready=1 at cycle 7, q_exp=0, q_fb=0, no done pulse.
REQ-032 set_req pulse at an edge while ready=1 -> S=1 for 4 cycles, then 2 guard cycles, then done=1 for one cycle with q_exp=1 and q_fb=1.
REQ-033 set_req=clr_req=1 while ready=1 -> conflict=1 for one cycle, S=R=0, ready stays 1.
REQ-034 clr_req pulse during an active SET_P pulse -> ignored, and S remains a 4-cycle pulse.
REQ-035 With SR_READBACK_EN defined, q_fb forced to 0 during a set -> err=1 at the last GUARD cycle and it remains 1 after further good transactions.
REQ-036 reset asserted in the 2nd cycle of an S pulse -> S=0 in the next cycle, then the INIT_R sequence repeats.
